// File: rtl/aes_key_sched_ctrl_if.sv
// Signal bundle between the key-schedule controller and its neighbours:
// key-load path, AES-128 expansion engine and the round datapath consumer.
interface aes_key_sched_ctrl_if #(
    parameter int KEY_S = 128,
    parameter int RND_W = 4
);
    logic             key_valid;
    logic [KEY_S-1:0] key;
    logic             key_ready;
    logic             rk_en;
    logic [KEY_S-1:0] rk_key;
    logic [KEY_S-1:0] rk_round_key;
    logic             rk_w_e;
    logic [RND_W-1:0] rk_round_no;
    logic             rk_en_o;
    logic             req_valid;
    logic             req_decrypt;
    logic             req_ready;
    logic             ko_valid;
    logic             ko_ready;
    logic [KEY_S-1:0] ko_key;
    logic [RND_W-1:0] ko_idx;
    logic             ko_last;
    logic             keys_valid;

    // master: the environment (key loader, engine, consumer); slave: the controller
    modport master (
        output key_valid, key, rk_round_key, rk_w_e, rk_round_no, rk_en_o,
               req_valid, req_decrypt, ko_ready,
        input  key_ready, rk_en, rk_key, req_ready, ko_valid, ko_key, ko_idx,
               ko_last, keys_valid
    );

    modport slave (
        input  key_valid, key, rk_round_key, rk_w_e, rk_round_no, rk_en_o,
               req_valid, req_decrypt, ko_ready,
        output key_ready, rk_en, rk_key, req_ready, ko_valid, ko_key, ko_idx,
               ko_last, keys_valid
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: starts one expansion per key, captures the
// NR+1 round keys and streams them forward (encrypt) or reverse (decrypt).
module aes_key_sched_ctrl #(
    parameter int KEY_S = 128,
    parameter int NR    = 10,
    parameter int RND_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    aes_key_sched_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

    localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NR);
    localparam logic [RND_W-1:0] ONE      = RND_W'(1);

    state_t           state_q, state_d;
    logic [KEY_S-1:0] store [NR+1];
    logic             rk_en_q, keys_valid_q, decrypt_q;
    logic [KEY_S-1:0] rk_key_q, ko_key_q;
    logic             ko_valid_q, ko_last_q;
    logic [RND_W-1:0] ko_idx_q;
    logic             key_acc, req_acc, beat_acc;
    logic [RND_W-1:0] first_idx, req_end_idx, end_idx, next_idx;

    assign bus.key_ready  = (state_q == IDLE) || (state_q == READY);
    assign bus.req_ready  = (state_q == READY);
    assign bus.rk_en      = rk_en_q;
    assign bus.rk_key     = rk_key_q;
    assign bus.ko_valid   = ko_valid_q;
    assign bus.ko_key     = ko_key_q;
    assign bus.ko_idx     = ko_idx_q;
    assign bus.ko_last    = ko_last_q;
    assign bus.keys_valid = keys_valid_q;

    // A key arriving together with a request takes priority over it.
    assign key_acc  = bus.key_valid && bus.key_ready;
    assign req_acc  = bus.req_valid && bus.req_ready && !bus.key_valid;
    assign beat_acc = ko_valid_q && bus.ko_ready;

    assign first_idx   = bus.req_decrypt ? LAST_IDX : '0;
    assign req_end_idx = bus.req_decrypt ? '0 : LAST_IDX;
    assign end_idx     = decrypt_q ? '0 : LAST_IDX;
    assign next_idx    = decrypt_q ? (ko_idx_q - ONE) : (ko_idx_q + ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (key_acc) state_d = EXPAND;
            EXPAND:  if (bus.rk_en_o) state_d = READY;
            READY: begin
                if (key_acc)      state_d = EXPAND;
                else if (req_acc) state_d = STREAM;
            end
            STREAM:  if (beat_acc && ko_last_q) state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rk_en_q      <= 1'b0;
            rk_key_q     <= '0;
            keys_valid_q <= 1'b0;
            decrypt_q    <= 1'b0;
            ko_valid_q   <= 1'b0;
            ko_key_q     <= '0;
            ko_idx_q     <= '0;
            ko_last_q    <= 1'b0;
        end else begin
            rk_en_q <= key_acc;
            if (key_acc) begin
                rk_key_q     <= bus.key;
                keys_valid_q <= 1'b0;
            end else if (state_q == EXPAND && bus.rk_en_o) begin
                keys_valid_q <= 1'b1;
            end

            if (req_acc) begin
                decrypt_q  <= bus.req_decrypt;
                ko_valid_q <= 1'b1;
                ko_idx_q   <= first_idx;
                ko_key_q   <= store[first_idx];
                ko_last_q  <= (first_idx == req_end_idx);
            end else if (beat_acc) begin
                if (ko_last_q) begin
                    ko_valid_q <= 1'b0;
                    ko_last_q  <= 1'b0;
                end else begin
                    ko_idx_q  <= next_idx;
                    ko_key_q  <= store[next_idx];
                    ko_last_q <= (next_idx == end_idx);
                end
            end
        end
    end

    // NOTE: the key store has no reset; keys_valid and the FSM gate every read of it.
    always_ff @(posedge clk) begin
        if (state_q == EXPAND && bus.rk_w_e && bus.rk_round_no <= LAST_IDX)
            store[bus.rk_round_no] <= bus.rk_round_key;
    end
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequences the AES-128 round-key expansion engine and stores its results.
- Accepts a cipher key and starts one expansion run. Captures the 11 round keys (index 0..NR) into a local key store.
- Streams the stored keys to the round datapath in forward order (encrypt) or reverse order (decrypt), using a valid/ready handshake.
- Sits between the key-load path and the cipher core, so one expansion serves any number of blocks.

Parameters:
- KEY_S, 128, key and round-key width in bits.
- NR, 10, number of AES rounds; the store holds NR+1 keys.
- RND_W, 4, width of round indices.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  a new cipher key is presented
- key  in  KEY_S  cipher key
- key_ready  out  1  controller can accept a key
- rk_en  out  1  one-cycle start pulse to the expansion engine
- rk_key  out  KEY_S  key driven to the expansion engine
- rk_round_key  in  KEY_S  round key from the engine
- rk_w_e  in  1  rk_round_key and rk_round_no are valid this cycle
- rk_round_no  in  RND_W  index of rk_round_key
- rk_en_o  in  1  engine finished; coincides with the write of index NR
- req_valid  in  1  request to stream the key set
- req_decrypt  in  1  stream order select, sampled at request accept: 0 = index 0..NR, 1 = index NR..0
- req_ready  out  1  controller can accept a stream request
- ko_valid  out  1  streamed key valid
- ko_ready  in  1  consumer accepts the streamed key
- ko_key  out  KEY_S  streamed round key
- ko_idx  out  RND_W  index of ko_key
- ko_last  out  1  final beat of the stream
- keys_valid  out  1  the store holds a complete key set for the last accepted key

Behaviour:
- Reset (asynchronous, all outputs registered):
  - State = IDLE.
  - rk_en, rk_key, ko_valid, ko_key, ko_idx, ko_last and keys_valid all = 0.
  - Store contents are don't-care.
- States:
  - IDLE: key_ready = 1, req_ready = 0.
  - EXPAND: key_ready = 0, req_ready = 0.
  - READY: key_ready = 1, req_ready = 1.
  - STREAM: key_ready = 0, req_ready = 0.
- Key accept (key_valid && key_ready in cycle T; IDLE or READY):
  - Latch key into rk_key.
  - rk_en = 1 in cycle T+1 only.
  - keys_valid = 0 from T+1.
  - State = EXPAND.
- EXPAND capture:
  - Each cycle with rk_w_e = 1 and rk_round_no <= NR: store[rk_round_no] <= rk_round_key.
  - rk_w_e with rk_round_no > NR is ignored.
  - Engine delivers indices 0..NR on consecutive cycles T+2..T+12.
- Expansion done:
  - rk_en_o = 1 in EXPAND → keys_valid = 1 and state = READY in the next cycle (T+13 nominal).
  - The index-NR write in the same cycle is stored.
- Outside EXPAND, rk_w_e and rk_en_o are ignored; the store is never written.
- Request accept (req_valid && req_ready in cycle T, READY only):
  - Latch req_decrypt. State = STREAM.
  - ko_valid = 1 at T+1 with the first key: idx 0 for encrypt, NR for decrypt.
- Stream handshake:
  - While ko_valid && !ko_ready, ko_key, ko_idx and ko_last hold stable.
  - On ko_valid && ko_ready, the next key appears the following cycle with no bubble. 11 beats take 11 cycles when ko_ready is held high.
  - ko_last = 1 on idx NR (encrypt) or idx 0 (decrypt).
- Stream end: the last beat accepted → ko_valid = 0 and ko_last = 0 next cycle, state = READY.
- Simultaneous events:
  - key_valid and req_valid both high in READY: the key wins; the request is not accepted (req_ready drops next cycle).
  - key_valid in EXPAND or STREAM is held off (key_ready = 0); it is never lost or truncated.
- Reset mid-operation:
  - Expansion or stream aborts immediately; keys_valid = 0.
  - A new key must be loaded before any request is accepted.
  - The engine shares this reset.
- Index arithmetic:
  - RND_W wide with no wrap. Encrypt counts up to NR; decrypt counts down to 0.
  - Termination is by ko_last, never by counter overflow.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c accepted at T → rk_en pulses at T+1 only; keys_valid = 1 at T+13; store[1] = a0fafe1788542cb123a339392a6c7605; store[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Encrypt request with ko_ready held 1 → 11 consecutive beats, idx 0..10; ko_last only on idx 10 (key d014f9a8…); ko_valid = 0 the cycle after; req_ready = 1.
- Decrypt request with ko_ready toggling 1,0,1,0… → idx 10..0 in order; ko_key stable across stall cycles; ko_last on idx 0 (key 2b7e1516…); no duplicated or skipped index.
- Second key 000102030405060708090a0b0c0d0e0f loaded in READY → keys_valid = 0 at next cycle; req_ready = 0 until re-expansion completes; then store[10] = 13111d7fe3944a17f307a78b4d2b30c5.
- Assert reset at the 5th rk_w_e of an expansion → keys_valid = 0, ko_valid = 0 and rk_en = 0 immediately; req_valid then ignored (req_ready = 0) until a new key completes expansion.
- Inject rk_w_e with rk_round_no = 12, and rk_en_o while in READY → store unchanged; keys_valid stays 1; state stays READY.
